// File: rtl/key_conditioner.sv
// ============================================================================
// key_conditioner : sync + debounce raw active-low keys, emit press/release
// Revision 1.0
// ============================================================================
`default_nettype none

module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n_raw,
  output logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] s;

  // Synchroniser idles at 1 so a reset never looks like a held key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             key_nxt;
    logic             key_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= UP;
        cnt       <= '0;
        key_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        key_q     <= key_nxt;
        press_q   <= key_nxt & ~key_q;
        release_q <= ~key_nxt & key_q;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        UP: begin
          if (s[i]) begin
            state_nxt = WAIT_DN;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt   = '0;
          end
        end
        WAIT_DN: begin
          if (!s[i]) begin
            state_nxt = UP;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = DOWN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
        DOWN: begin
          if (!s[i]) begin
            state_nxt = WAIT_UP;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt   = '0;
          end
        end
        WAIT_UP: begin
          if (s[i]) begin
            state_nxt = DOWN;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = UP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign key_nxt        = (state_nxt == DOWN) || (state_nxt == WAIT_UP);
    assign key[i]         = key_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4, N_KEYS=3).
`timescale 1ns/1ps
`default_nettype none

module tb_key_conditioner;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] key_n_raw = '1;
  logic [N-1:0] key;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  // Reference model: two-sample delay, then a run-length filter that accepts
  // a new level once it has been seen D+1 consecutive samples.
  logic [N-1:0] m_sync1, m_sync2, m_key, m_press, m_rel;
  int           run [N];
  int           checks = 0;
  int           passed = 0;
  int           cyc    = 0;

  key_conditioner #(.N_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n_raw  (key_n_raw),
    .key        (key),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sync1 = '1;
    m_sync2 = '1;
    m_key   = '0;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  task automatic step();
    logic [N-1:0] sv;
    logic [N-1:0] old;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      sv  = ~m_sync2;
      old = m_key;
      for (int i = 0; i < N; i++) begin
        if (sv[i] !== m_key[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            m_key[i] = sv[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_press = m_key & ~old;
      m_rel   = old & ~m_key;
      m_sync2 = m_sync1;
      m_sync1 = key_n_raw;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_n_raw = 3'b000;
    model_reset();
    repeat (5) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== 9'b0) begin
        $display("FAIL reset_hold cyc=%0d key/press/rel=%b/%b/%b expected 000/000/000",
                 cyc, key, key_press, key_release);
      end else passed++;
    end
    rst = 1'b1;
    repeat (10) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL reset_release cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
    end
    key_n_raw = '1;
    repeat (10) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL reset_settle cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
    end
  endtask

  task automatic test_single_press();
    int lat = -1;
    int presses = 0;
    key_n_raw[0] = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL single_press cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      if (key[0] && lat < 0) lat = n;
      if (key_press[0]) presses++;
    end
    checks++;
    if (lat !== LAT || presses !== 1) begin
      $display("FAIL single_press_latency latency=%0d presses=%0d expected %0d/1", lat, presses, LAT);
    end else passed++;
  endtask

  task automatic test_bounce_press();
    int lat = -1;
    int presses = 0;
    key_n_raw[1] = 1'b0;
    step();
    step();
    key_n_raw[1] = 1'b1;
    step();
    key_n_raw[1] = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL bounce_press cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      if (key[1] && lat < 0) lat = n;
      if (key_press[1]) presses++;
    end
    checks++;
    if (lat !== LAT || presses !== 1) begin
      $display("FAIL bounce_press_latency latency=%0d presses=%0d expected %0d/1", lat, presses, LAT);
    end else passed++;
    key_n_raw = '1;
    repeat (12) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL bounce_settle cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
    end
  endtask

  task automatic test_glitch_release();
    int lat = -1;
    int rels = 0;
    int pulses = 0;
    key_n_raw[0] = 1'b0;
    repeat (3) step();
    key_n_raw[0] = 1'b1;
    repeat (12) begin
      step();
      if (key[0] || key_press[0] || key_release[0]) pulses++;
    end
    checks++;
    if (pulses !== 0 || m_key[0] !== 1'b0) begin
      $display("FAIL glitch_reject activity_cycles=%0d expected 0", pulses);
    end else passed++;
    key_n_raw[0] = 1'b0;
    repeat (12) step();
    checks++;
    if (key[0] !== 1'b1) begin
      $display("FAIL glitch_hold key0=%b expected 1", key[0]);
    end else passed++;
    key_n_raw[0] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL release cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      if (!key[0] && lat < 0) lat = n;
      if (key_release[0]) rels++;
    end
    checks++;
    if (lat !== LAT || rels !== 1) begin
      $display("FAIL release_latency latency=%0d releases=%0d expected %0d/1", lat, rels, LAT);
    end else passed++;
  endtask

  task automatic test_simultaneous();
    int lat = -1;
    logic [N-1:0] k_at = '0;
    logic [N-1:0] p_at = '0;
    key_n_raw = 3'b010;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL simultaneous cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      if (key !== '0 && lat < 0) begin
        lat  = n;
        k_at = key;
        p_at = key_press;
      end
    end
    checks++;
    if (lat !== LAT || k_at !== 3'b101 || p_at !== 3'b101) begin
      $display("FAIL simultaneous_edge latency=%0d key=%b press=%b expected %0d/101/101",
               lat, k_at, p_at, LAT);
    end else passed++;
    key_n_raw = '1;
    repeat (12) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL simultaneous_settle cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
    end
  endtask

  task automatic test_reset_mid_count();
    int lat = -1;
    int presses = 0;
    key_n_raw[2] = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({key, key_press, key_release} !== 9'b0) begin
      $display("FAIL reset_async key/press/rel=%b/%b/%b expected 000/000/000",
               key, key_press, key_release);
    end else passed++;
    repeat (2) step();
    rst = 1'b1;
    // First post-reset edge samples the still-held key; latency counts from there.
    for (int n = 0; n < 16; n++) begin
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL reset_mid cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      if (key[2] && lat < 0) lat = n;
      if (key_press[2]) presses++;
    end
    checks++;
    if (lat !== LAT || presses !== 1) begin
      $display("FAIL reset_mid_latency latency=%0d presses=%0d expected %0d/1", lat, presses, LAT);
    end else passed++;
    key_n_raw = '1;
    repeat (12) step();
  endtask

  task automatic test_random();
    int hold [N];
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 9);
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rst = 1'b0;
        model_reset();
      end
      if (c == 203) rst = 1'b1;
      step();
      checks++;
      if ({key, key_press, key_release} !== {m_key, m_press, m_rel}) begin
        $display("FAIL random cyc=%0d key/press/rel=%b/%b/%b expected %b/%b/%b",
                 cyc, key, key_press, key_release, m_key, m_press, m_rel);
      end else passed++;
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          key_n_raw[i] = ~key_n_raw[i];
          hold[i] = $urandom_range(1, 9);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce_press();
    test_glitch_release();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
